ex_operand_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the integer ALU.
- Registers one decoded operation per handshake and resolves register operands against MEM- and WB-stage results (bypass forwarding).
- Selects immediate/PC substitutes and presents src1/src2/func1/func2 to the ALU.
- Holds its entry under downstream back-pressure, refreshing stored operands from forwarding so retiring results are never lost.

---
 rtl/ex_operand_stage.sv | 163 ++++++++++++++++
 tb/tb_ex_operand_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: single-entry buffer with MEM/WB bypass and hold refresh.
// Optional EX_STALL_CNT_EN adds a saturating back-pressure counter (stall_cnt_o).
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              use_pc_i,
  input  logic              use_imm_i,
  input  logic [3:0]        func1_i,
  input  logic [1:0]        func2_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_we_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        func1_o,
  output logic [1:0]        func2_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              rd_we_o
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;
    logic              use_pc;
    logic              use_imm;
    logic [3:0]        func1;
    logic [1:0]        func2;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
  } entry_t;

  entry_t q;
  entry_t cap;
  logic   valid;
  logic   accept;
  logic   hold;

  logic [DATA_W-1:0] cap1, cap2;
  logic [DATA_W-1:0] held1, held2;

  // x0 reads as zero even when a bypass source targets it
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] a,
    input logic [DATA_W-1:0] d,
    input logic              mwe,
    input logic [REG_AW-1:0] ma,
    input logic [DATA_W-1:0] md,
    input logic              wwe,
    input logic [REG_AW-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] r;
    r = d;
    if (a == '0)
      r = '0;
    else if (FWD_EN && mwe && ma == a)
      r = md;
    else if (FWD_EN && wwe && wa == a)
      r = wd;
    return r;
  endfunction

  assign cap1 = fwd(rs1_addr_i, rs1_data_i,
                    mem_we_i, mem_addr_i, mem_data_i,
                    wb_we_i, wb_addr_i, wb_data_i);
  assign cap2 = fwd(rs2_addr_i, rs2_data_i,
                    mem_we_i, mem_addr_i, mem_data_i,
                    wb_we_i, wb_addr_i, wb_data_i);
  assign held1 = fwd(q.rs1_addr, q.rs1_val,
                     mem_we_i, mem_addr_i, mem_data_i,
                     wb_we_i, wb_addr_i, wb_data_i);
  assign held2 = fwd(q.rs2_addr, q.rs2_val,
                     mem_we_i, mem_addr_i, mem_data_i,
                     wb_we_i, wb_addr_i, wb_data_i);

  assign in_ready_o = !valid || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign hold       = valid && !out_ready_i;

  always_comb begin
    cap          = '0;
    cap.pc       = pc_i;
    cap.rs1_addr = rs1_addr_i;
    cap.rs2_addr = rs2_addr_i;
    cap.rs1_val  = cap1;
    cap.rs2_val  = cap2;
    cap.imm      = imm_i;
    cap.use_pc   = use_pc_i;
    cap.use_imm  = use_imm_i;
    cap.func1    = func1_i;
    cap.func2    = func2_i;
    cap.rd_addr  = rd_addr_i;
    cap.rd_we    = rd_we_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush_i) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      q     <= cap;
    end else if (valid && out_ready_i) begin
      valid <= 1'b0;
    end else if (hold) begin
      // retiring results must survive a long stall
      q.rs1_val <= held1;
      q.rs2_val <= held2;
    end
  end

  assign out_valid_o = valid;
  assign src1_o      = q.use_pc  ? q.pc  : held1;
  assign src2_o      = q.use_imm ? q.imm : held2;
  assign func1_o     = q.func1;
  assign func2_o     = q.func2;
  assign pc_o        = q.pc;
  assign rd_addr_o   = q.rd_addr;
  assign rd_we_o     = q.rd_we;

`ifdef EX_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      stall_cnt_o <= '0;
    else if (flush_i)
      stall_cnt_o <= '0;
    else if (hold && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: vector table, directed sequences, random vs model.
// Build with EX_STALL_CNT_EN to also exercise the stall counter.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [31:0] imm_i;
  logic        use_pc_i, use_imm_i;
  logic [3:0]  func1_i;
  logic [1:0]  func2_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic        mem_we_i;
  logic [4:0]  mem_addr_i;
  logic [31:0] mem_data_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] src1_o, src2_o;
  logic [3:0]  func1_o;
  logic [1:0]  func2_o;
  logic [31:0] pc_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .use_pc_i(use_pc_i), .use_imm_i(use_imm_i),
    .func1_i(func1_i), .func2_i(func2_i),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .src1_o(src1_o), .src2_o(src2_o),
    .func1_o(func1_o), .func2_o(func2_o),
    .pc_o(pc_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o)
`ifdef EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    mem_we_i = 0; mem_addr_i = 0; mem_data_i = 0;
    wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [4:0] a1,
                        input logic [31:0] d1, input logic [4:0] a2,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic upc, input logic uimm,
                        input logic [3:0] f1);
    pc_i = pc; rs1_addr_i = a1; rs1_data_i = d1;
    rs2_addr_i = a2; rs2_data_i = d2; imm_i = imm;
    use_pc_i = upc; use_imm_i = uimm; func1_i = f1;
    func2_i = f1[1:0]; rd_addr_i = a1 ^ a2; rd_we_i = f1[0];
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  a2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        upc, uimm;
    logic [3:0]  f1;
    logic        mwe;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e1, e2;
  } vec_t;

  // reference model: pending-op record with bypass applied by rule
  typedef struct {
    logic [31:0] pc, imm, v1, v2;
    logic [4:0]  a1, a2, rd;
    logic        upc, uimm, rdwe;
    logic [3:0]  f1;
    logic [1:0]  f2;
  } mop_t;

  function automatic logic [31:0] mf(input logic [4:0] a,
                                     input logic [31:0] d);
    if (a == 0) return 0;
    if (mem_we_i && mem_addr_i == a) return mem_data_i;
    if (wb_we_i && wb_addr_i == a) return wb_data_i;
    return d;
  endfunction

  vec_t vt[6];
  mop_t m;
  bit   mv;
  bit   rdy, acc;

  initial begin
    reset_i = 0; in_valid_i = 0; out_ready_i = 0; flush_i = 0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clr_fwd();
    #12;
    chk("rst_valid", {31'd0, out_valid_o}, 0);
    chk("rst_src1", src1_o, 0);
    chk("rst_src2", src2_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_func", {26'd0, func2_o, func1_o}, 0);
    chk("rst_rd", {26'd0, rd_we_o, rd_addr_o}, 0);
    chk("rst_ready", {31'd0, in_ready_o}, 1);
    reset_i = 1;
    tick();

    vt[0] = '{32'h100, 3, 32'h10, 4, 32'h20, 0, 0, 0, 0,
              0, 0, 0, 0, 0, 0, 32'h10, 32'h20};
    vt[1] = '{32'h104, 5, 32'h1, 6, 32'h2, 0, 0, 0, 1,
              1, 5, 32'hAAAA, 1, 5, 32'hBBBB, 32'hAAAA, 32'h2};
    vt[2] = '{32'h108, 5, 32'h1, 6, 32'h2, 0, 0, 0, 2,
              0, 5, 32'hAAAA, 1, 5, 32'hBBBB, 32'hBBBB, 32'h2};
    vt[3] = '{32'h10C, 0, 32'h1234, 6, 32'h2, 0, 0, 0, 3,
              1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 32'h0, 32'h2};
    vt[4] = '{32'h2000, 1, 32'h1, 2, 32'h2, 32'hFFFFFFFC, 1, 1, 4,
              1, 1, 32'hAAAA, 1, 2, 32'hBBBB, 32'h2000, 32'hFFFFFFFC};
    vt[5] = '{32'h110, 9, 32'h9, 8, 32'h8, 0, 0, 0, 5,
              1, 8, 32'h77, 1, 9, 32'h99, 32'h99, 32'h77};

    out_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      set_op(vt[i].pc, vt[i].a1, vt[i].d1, vt[i].a2, vt[i].d2,
             vt[i].imm, vt[i].upc, vt[i].uimm, vt[i].f1);
      mem_we_i = vt[i].mwe; mem_addr_i = vt[i].ma;
      mem_data_i = vt[i].md;
      wb_we_i = vt[i].wwe; wb_addr_i = vt[i].wa; wb_data_i = vt[i].wd;
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid_o}, 1);
      chk($sformatf("v%0d_src1", i), src1_o, vt[i].e1);
      chk($sformatf("v%0d_src2", i), src2_o, vt[i].e2);
      chk($sformatf("v%0d_func1", i), {28'd0, func1_o},
          {28'd0, vt[i].f1});
      chk($sformatf("v%0d_pc", i), pc_o, vt[i].pc);
    end
    clr_fwd();
    tick();
    chk("drain", {31'd0, out_valid_o}, 0);

    // hold refresh: stale x7 replaced by a one-cycle WB write
    out_ready_i = 0;
    set_op(32'h300, 1, 32'h1, 7, 32'h11, 0, 0, 0, 6);
    in_valid_i = 1;
    tick();
    in_valid_i = 0;
    chk("hold_stale", src2_o, 32'h11);
    chk("hold_rdy0", {31'd0, in_ready_o}, 0);
    wb_we_i = 1; wb_addr_i = 7; wb_data_i = 32'h55;
    #1;
    chk("hold_fwd", src2_o, 32'h55);
    tick();
    clr_fwd();
    #1;
    chk("hold_kept", src2_o, 32'h55);
    chk("hold_rdy1", {31'd0, in_ready_o}, 0);
    chk("hold_valid", {31'd0, out_valid_o}, 1);
    tick();
    chk("hold_kept2", src2_o, 32'h55);
    out_ready_i = 1;
    tick();
    chk("hold_drain", {31'd0, out_valid_o}, 0);

    // flush kills the 2nd op of a stream
    set_op(32'h400, 1, 1, 2, 2, 0, 0, 0, 1);
    in_valid_i = 1;
    tick();
    chk("fl_op1", {27'd0, out_valid_o, func1_o}, {27'd0, 1'b1, 4'd1});
    set_op(32'h404, 1, 1, 2, 2, 0, 0, 0, 2);
    flush_i = 1;
    #1;
    chk("fl_ready", {31'd0, in_ready_o}, 1);
    tick();
    chk("fl_gone", {31'd0, out_valid_o}, 0);
    flush_i = 0;
    set_op(32'h408, 1, 1, 2, 2, 0, 0, 0, 3);
    tick();
    chk("fl_op3", {27'd0, out_valid_o, func1_o}, {27'd0, 1'b1, 4'd3});
    for (int k = 0; k < 3; k++) begin
      set_op(32'h500 + k, 1, 1, 2, 2, 0, 0, 0, 4'(8 + k));
      tick();
      chk($sformatf("str%0d", k), {27'd0, out_valid_o, func1_o},
          {27'd0, 1'b1, 4'(8 + k)});
    end
    in_valid_i = 0;
    tick();
    chk("str_end", {31'd0, out_valid_o}, 0);

`ifdef EX_STALL_CNT_EN
    flush_i = 1;
    tick();
    flush_i = 0;
    in_valid_i = 1;
    out_ready_i = 0;
    tick();
    in_valid_i = 0;
    repeat (5) tick();
    chk("stall5", stall_cnt, 5);
    flush_i = 1;
    tick();
    flush_i = 0;
    chk("stall_clr", stall_cnt, 0);
`endif

    // async reset while holding
    out_ready_i = 0;
    set_op(32'h600, 3, 32'h33, 4, 32'h44, 0, 0, 0, 7);
    in_valid_i = 1;
    tick();
    in_valid_i = 0;
    chk("mh_valid", {31'd0, out_valid_o}, 1);
    reset_i = 0;
    #1;
    chk("mh_rst_valid", {31'd0, out_valid_o}, 0);
    chk("mh_rst_src1", src1_o, 0);
    #1;
    reset_i = 1;
    mv = 0;
    tick();

    for (int n = 0; n < 500; n++) begin
      in_valid_i  = ($urandom_range(3) != 0);
      out_ready_i = ($urandom_range(2) != 0);
      flush_i     = ($urandom_range(15) == 0);
      set_op($urandom, 5'($urandom_range(7)), $urandom,
             5'($urandom_range(7)), $urandom, $urandom,
             ($urandom_range(3) == 0), ($urandom_range(3) == 0),
             4'($urandom));
      mem_we_i = $urandom_range(1); mem_addr_i = 5'($urandom_range(7));
      mem_data_i = $urandom;
      wb_we_i = $urandom_range(1); wb_addr_i = 5'($urandom_range(7));
      wb_data_i = $urandom;
      #1;
      rdy = !mv || out_ready_i;
      chk("r_valid", {31'd0, out_valid_o}, {31'd0, mv});
      chk("r_ready", {31'd0, in_ready_o}, {31'd0, rdy});
      if (mv) begin
        chk("r_src1", src1_o, m.upc ? m.pc : mf(m.a1, m.v1));
        chk("r_src2", src2_o, m.uimm ? m.imm : mf(m.a2, m.v2));
        chk("r_ctl", {22'd0, rd_we_o, rd_addr_o, func2_o, func1_o},
            {22'd0, m.rdwe, m.rd, m.f2, m.f1});
        chk("r_pc", pc_o, m.pc);
      end
      acc = in_valid_i && rdy && !flush_i;
      if (flush_i) mv = 0;
      else if (acc) begin
        mv = 1;
        m.pc = pc_i; m.imm = imm_i;
        m.a1 = rs1_addr_i; m.a2 = rs2_addr_i;
        m.v1 = mf(rs1_addr_i, rs1_data_i);
        m.v2 = mf(rs2_addr_i, rs2_data_i);
        m.upc = use_pc_i; m.uimm = use_imm_i;
        m.f1 = func1_i; m.f2 = func2_i;
        m.rd = rd_addr_i; m.rdwe = rd_we_i;
      end else if (mv && out_ready_i) mv = 0;
      else if (mv) begin
        m.v1 = mf(m.a1, m.v1);
        m.v2 = mf(m.a2, m.v2);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
